// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, counter sizing, width limit.
package serial_sub_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // One spare bit so the counter can never wrap within an operation.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor built from two half subtractors.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic borrow1;
  logic borrow2;

  half_subtractor u_hs0 (
    .a      (a),
    .b      (b),
    .diff   (d1),
    .borrow (borrow1)
  );

  half_subtractor u_hs1 (
    .a      (d1),
    .b      (bin),
    .diff   (diff),
    .borrow (borrow2)
  );

  assign bout = borrow1 | borrow2;

endmodule

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: diff = a - b, borrow when a < b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (LSB first) with valid/ready on both sides.
// Optional zero-result flag output enabled by SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;
  logic             load;
  logic             step;
  logic             finish;
  logic             retire;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d),
    .bout (bo)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, borrow chain, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        br   <= 1'b0;
        cnt  <= '0;
      end
      if (step) begin
        // New bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
        diff <= (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        br   <= bo;
        cnt  <= cnt + CW'(1);
      end
      if (finish) begin
        borrow    <= bo;
        out_valid <= 1'b1;
      end
      if (retire) out_valid <= 1'b0;
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic nz;

  // Sticky record of any set result bit; resolved into zero on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz   <= 1'b0;
      zero <= 1'b0;
    end else begin
      if (load)   nz   <= 1'b0;
      if (step)   nz   <= nz | d;
      if (finish) zero <= ~(nz | d);
    end
  end
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor that consumes two WIDTH-bit operands and produces diff = a - b with a final borrow.
- Each cycle resolves one bit, LSB first, through a full-subtractor cell built from two half_subtractor instances plus a registered borrow.
- Sits directly downstream of the half_subtractor cell: it is the first sequential consumer of its diff/borrow outputs.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block idle and able to accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  final borrow; 1 iff a < b.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values, applied on the first clk edge with rst_n low:
  - state = IDLE; out_valid = 0; diff = 0; borrow = 0; busy = 0.
  - Internal operand shift registers, borrow register and bit counter all = 0.
  - in_ready = 1 after that edge; in_ready is decoded from state == IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load a and b into shift registers, clear the borrow register, set cnt = 0, go to RUN.
  - a and b are sampled only on this edge.
- RUN:
  - in_ready = 0.
  - Each cycle, the full-subtractor cell takes ai = a_sh[0], bi = b_sh[0] and br (borrow register).
  - d = ai ^ bi ^ br; bo = (~ai & bi) | (~(ai ^ bi) & br).
  - d is shifted into the diff register at the MSB (right shift); a_sh and b_sh shift right; br <= bo; cnt++.
  - On the edge where cnt == WIDTH-1: borrow <= bo, out_valid <= 1, go to DONE.
- DONE:
  - diff, borrow and out_valid are held stable until out_valid && out_ready.
  - On that edge: out_valid <= 0, go to IDLE.
  - in_ready rises the cycle after the handshake; there is no same-cycle accept on a completing result.
- Latency: out_valid high exactly WIDTH cycles after the accepting edge.
- Minimum issue interval: WIDTH + 2 cycles (with out_ready held high).
- in_valid is ignored outside IDLE; operands presented while busy are not latched.
- out_ready is ignored outside DONE.
- WIDTH == 1: RUN lasts one cycle; cnt compare is against 0.
- Reset mid-RUN or mid-DONE: operation abandoned; no out_valid pulse; diff and borrow cleared; IDLE on the next edge.
- Counter width: $clog2(WIDTH)+1 bits; no wrap is possible within an operation.

Optional Feature:
- Macro: SERIAL_SUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - A sticky register, cleared on accept, records any d == 1 during RUN.
  - zero = 1 in DONE iff every diff bit was 0; updated on the same edge as out_valid; held until the handshake.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg:
  - State encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - Counter-width function.
  - Max WIDTH constant (32).
- Sub-module full_subtractor (inputs a, b, bin; outputs diff, bout):
  - Composed of two half_subtractor instances.
  - bout = borrow1 | borrow2.
  - serial_subtractor instantiates one full_subtractor.

Test Plan:
- WIDTH=8, a=200, b=55, out_ready=1 -> out_valid high 8 cycles after accept, diff=145, borrow=0, in_ready=1 one cycle after handshake.
- a=5, b=10 -> diff=251 (0xFB), borrow=1; with SERIAL_SUB_ZERO_FLAG_EN, zero=0.
- a=0x5A, b=0x5A -> diff=0x00, borrow=0; zero=1 when the macro is defined.
- Back-pressure: a=0x00, b=0x01, out_ready low for 5 cycles in DONE -> diff=0xFF and borrow=1 held constant, busy=1, in_ready=0; a second in_valid with a=0x33 during the stall is not latched; result retires on the first out_ready.
- rst_n low for one cycle, 3 cycles into RUN -> no out_valid pulse, diff=0, in_ready=1 next cycle; following op a=0xFF, b=0xFF -> diff=0, borrow=0.
- Back-to-back with in_valid and out_ready tied 1: ops (0x00-0x01) then (0x80-0x7F) -> results 0xFF/1 then 0x01/0; accepts spaced exactly 10 cycles apart.
